// File: rtl/tick_sched_ctrl.sv
// tick_sched_ctrl: programmable game-tick scheduler with start/stop/pause/one-shot control
// Ports: i_clk/rst_n (async active-low); i_start, i_stop, i_pause, i_oneshot control;
//   i_div/i_div_valid/o_div_ready divisor handshake; o_tick one-cycle enable, o_phase
//   square wave, o_state (00 idle, 01 run, 10 pause); o_tick_cnt tick count since start.
// TICK_SCHED_STATS_EN: when defined, adds o_tick_cnt and its counter.
module tick_sched_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEFAULT_DIV = 10
`ifdef TICK_SCHED_STATS_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic             i_clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_pause,
  input  logic             i_oneshot,
  input  logic [WIDTH-1:0] i_div,
  input  logic             i_div_valid,
  output logic             o_div_ready,
  output logic             o_tick,
  output logic             o_phase,
  output logic [1:0]       o_state
`ifdef TICK_SCHED_STATS_EN
  , output logic [CNT_W-1:0] o_tick_cnt
`endif
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] div_q, pend_q, cnt, div_c;
  logic pend_v, oneshot_q, start, stop_run, cnt_en, wrap, xfer, direct;
  assign start = state == IDLE && i_start && !i_stop;
  assign stop_run = state != IDLE && i_stop;
  // the edge that releases a pause already counts, so P paused samples add exactly P cycles
  assign cnt_en = state != IDLE && !i_stop && !i_pause;
  assign wrap = cnt_en && cnt == div_q - WIDTH'(1);
  assign xfer = i_div_valid && !pend_v;
  assign div_c = i_div < WIDTH'(2) ? WIDTH'(2) : i_div;
  // a stopping edge goes straight to idle, so a divisor arriving then is applied directly
  assign direct = state == IDLE || i_stop;
  assign o_div_ready = !pend_v;
  assign o_state = state;
  always_comb begin
    state_d = state == IDLE ? (start ? RUN : IDLE) :
              i_stop ? IDLE :
              i_pause ? PAUSE :
              (wrap && oneshot_q) ? IDLE : RUN;
  end
  always_ff @(posedge i_clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge i_clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      div_q <= WIDTH'(DEFAULT_DIV);
      pend_q <= '0;
      pend_v <= 1'b0;
      oneshot_q <= 1'b0;
      o_tick <= 1'b0;
      o_phase <= 1'b0;
    end else begin
      if (start) begin
        cnt <= '0;
        oneshot_q <= i_oneshot;
      end else if (stop_run) cnt <= '0;
      else if (cnt_en) cnt <= wrap ? '0 : cnt + WIDTH'(1);
      o_tick <= wrap;
      o_phase <= stop_run ? 1'b0 : o_phase ^ wrap;
      if (pend_v && (wrap || i_stop)) begin
        div_q <= pend_q;
        pend_v <= 1'b0;
      end else if (xfer && direct) div_q <= div_c;
      else if (xfer) begin
        pend_q <= div_c;
        pend_v <= 1'b1;
      end
    end
`ifdef TICK_SCHED_STATS_EN
  always_ff @(posedge i_clk or negedge rst_n)
    if (!rst_n) o_tick_cnt <= '0;
    else if (start) o_tick_cnt <= '0;
    else if (wrap) o_tick_cnt <= o_tick_cnt + CNT_W'(1);
`endif
endmodule

// File: tb/tb_tick_sched_ctrl.sv
// tb_tick_sched_ctrl: directed self-checking bench for tick_sched_ctrl
module tb_tick_sched_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_start = 1'b0, i_stop = 1'b0, i_pause = 1'b0, i_oneshot = 1'b0, i_div_valid = 1'b0;
  logic [15:0] i_div = '0;
  logic o_div_ready, o_tick, o_phase;
  logic [1:0] o_state;
`ifdef TICK_SCHED_STATS_EN
  logic [7:0] o_tick_cnt;
`endif
  int tests = 0, fails = 0, n = 0, ticks = 0;
  tick_sched_ctrl dut (
    .i_clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop), .i_pause(i_pause),
    .i_oneshot(i_oneshot), .i_div(i_div), .i_div_valid(i_div_valid), .o_div_ready(o_div_ready),
    .o_tick(o_tick), .o_phase(o_phase), .o_state(o_state)
`ifdef TICK_SCHED_STATS_EN
    , .o_tick_cnt(o_tick_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      step(1);
      cycles++;
    end while (!o_tick && cycles < 100);
  endtask
  task automatic pulse_start(input logic os);
    i_start = 1'b1;
    i_oneshot = os;
    step(1);
    i_start = 1'b0;
    i_oneshot = 1'b0;
  endtask
  task automatic pulse_stop();
    i_stop = 1'b1;
    step(1);
    i_stop = 1'b0;
  endtask
  task automatic load_div(input logic [15:0] d);
    i_div = d;
    i_div_valid = 1'b1;
    step(1);
    i_div_valid = 1'b0;
  endtask
  initial begin
    step(2);
    chk("rst_tick", o_tick, 0);
    chk("rst_phase", o_phase, 0);
    chk("rst_state", o_state, 0);
    chk("rst_ready", o_div_ready, 1);
    rst_n = 1'b1;
    step(1);
    pulse_start(1'b0);
    chk("start_state", o_state, 1);
    wait_tick(n); chk("first_period", n, 10); chk("phase1", o_phase, 1);
    wait_tick(n); chk("second_period", n, 10); chk("phase2", o_phase, 0);
    wait_tick(n); chk("third_period", n, 10); chk("phase3", o_phase, 1);
    chk("run_state", o_state, 1);
`ifdef TICK_SCHED_STATS_EN
    chk("stats_three", o_tick_cnt, 3);
`endif
    step(3);
    load_div(16'd4);
    chk("pend_ready_low", o_div_ready, 0);
    wait_tick(n); chk("period_in_progress", n, 6);
    chk("ready_after_apply", o_div_ready, 1);
    wait_tick(n); chk("new_period_a", n, 4);
    wait_tick(n); chk("new_period_b", n, 4);
    wait_tick(n); chk("phase_before_stop", o_phase, 1);
    pulse_stop();
    chk("stop_state", o_state, 0);
    chk("stop_phase", o_phase, 0);
    chk("stop_tick", o_tick, 0);
    load_div(16'd0);
    chk("idle_load_ready", o_div_ready, 1);
    pulse_start(1'b0);
    wait_tick(n); chk("clamp_period_a", n, 2);
    wait_tick(n); chk("clamp_period_b", n, 2);
    pulse_stop();
    load_div(16'd10);
    pulse_start(1'b0);
    step(3);
    i_pause = 1'b1;
    step(1);
    chk("pause_state", o_state, 2);
    step(4);
    i_pause = 1'b0;
    wait_tick(n); chk("paused_period_rest", n, 7);
    chk("resume_state", o_state, 1);
    load_div(16'd3);
    chk("pend_before_stop", o_div_ready, 0);
    pulse_stop();
    chk("stop_apply_ready", o_div_ready, 1);
    pulse_start(1'b0);
    wait_tick(n); chk("stop_applied_div", n, 3);
    pulse_stop();
    load_div(16'd6);
    pulse_start(1'b1);
    wait_tick(n); chk("oneshot_period", n, 6);
    chk("oneshot_idle", o_state, 0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      ticks += int'(o_tick);
    end
    chk("oneshot_no_more", ticks, 0);
    i_start = 1'b1;
    i_stop = 1'b1;
    step(1);
    i_start = 1'b0;
    i_stop = 1'b0;
    chk("start_stop_idle", o_state, 0);
    pulse_start(1'b0);
    step(2);
    load_div(16'd5);
    chk("pend_before_rst", o_div_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_state", o_state, 0);
    chk("arst_ready", o_div_ready, 1);
    chk("arst_tick", o_tick, 0);
    chk("arst_phase", o_phase, 0);
`ifdef TICK_SCHED_STATS_EN
    chk("arst_stats", o_tick_cnt, 0);
`endif
    step(1);
    rst_n = 1'b1;
    step(1);
    pulse_start(1'b0);
    wait_tick(n); chk("div_after_rst", n, 10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
